nibble_pair_sampler: RTL and testbench

Upstream operand stage for the nibble adder. It synchronises the asynchronous operand pins and a raw push-button strobe, and debounces the strobe. On each debounced press it captures one operand pair: op_a from pins[7:4] and op_b from pins[3:0]. It presents the pair to the adder over a valid/ready handshake, and flags presses that are lost because the adder stalled.

---
 rtl/nibble_pkg.sv | 14 +
 rtl/sync_debounce.sv | 54 +++++
 rtl/nibble_pair_sampler.sv | 105 ++++++++++
 tb/tb_nibble_pair_sampler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared constants and types for the nibble adder operand path.
// Operand width, default debounce length and sampler FSM states.
package nibble_pkg;

  localparam int NIBBLE_W            = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VALID   = 2'd1,
    RELEASE = 2'd2
  } sampler_state_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus debouncer for one bouncy input.
// Emits the debounced level and one-cycle rise/fall pulses.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic [7:0] cnt;

  // bring the raw input into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // count consecutive disagreeing cycles; flip the level on the last one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      db_rise <= 1'b0;
      db_fall <= 1'b0;
      if (s2 == db_level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt      <= '0;
        db_level <= ~db_level;
        db_rise  <= ~db_level;
        db_fall  <= db_level;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/nibble_pair_sampler.sv
// Operand stage: syncs pins, debounces the strobe, captures a
// nibble pair per press and offers it over valid/ready.
module nibble_pair_sampler
  import nibble_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*NIBBLE_W-1:0] pins_in,
  input  logic                  strobe_in,
  output logic [NIBBLE_W-1:0]   op_a,
  output logic [NIBBLE_W-1:0]   op_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  logic [2*NIBBLE_W-1:0] pins_s1;
  logic [2*NIBBLE_W-1:0] pins_s2;
  logic                  db_level;
  logic                  db_rise;
  logic                  db_fall;

  sampler_state_t state;
  sampler_state_t state_n;
  logic           seen_release;
  logic           seen_n;
  logic           load;
  logic           set_ov;

  // plain two-flop bank for the operand pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pins_s1 <= '0;
      pins_s2 <= '0;
    end else begin
      pins_s1 <= pins_in;
      pins_s2 <= pins_s1;
    end
  end

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_strobe (
    .clk      (clk),
    .reset    (reset),
    .raw      (strobe_in),
    .db_level (db_level),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  // next state, capture enable and overrun detection
  always_comb begin
    state_n = state;
    seen_n  = seen_release;
    load    = 1'b0;
    set_ov  = 1'b0;
    unique case (state)
      IDLE: begin
        if (db_rise) begin
          load    = 1'b1;
          seen_n  = 1'b0;
          state_n = VALID;
        end
      end
      VALID: begin
        if (db_fall) seen_n = 1'b1;
        if (db_rise && seen_release) set_ov = 1'b1;
        if (op_ready) state_n = db_level ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!db_level) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered outputs; a set of overrun beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      seen_release <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_valid     <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      seen_release <= seen_n;
      op_valid     <= (state_n == VALID);
      busy         <= (state_n != IDLE);
      overrun      <= set_ov | (overrun & ~overrun_clr);
      if (load) begin
        op_a <= pins_s2[2*NIBBLE_W-1:NIBBLE_W];
        op_b <= pins_s2[NIBBLE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_nibble_pair_sampler.sv
// Randomised bench for nibble_pair_sampler against a
// window-based reference model, plus directed scenarios.
module tb_nibble_pair_sampler;
  import nibble_pkg::*;

  localparam int D = DEBOUNCE_CYCLES_DEF;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pins_in;
  logic       strobe_in;
  logic       op_ready;
  logic       overrun_clr;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_valid;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  nibble_pair_sampler dut (
    .clk         (clk),
    .reset       (reset),
    .pins_in     (pins_in),
    .strobe_in   (strobe_in),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: delay lines, a window of the last D synced
  // strobe samples, and transaction-level operand state
  bit       m_s1, m_s2;
  bit [7:0] m_p1, m_p2;
  bit       win[$];
  bit       m_db, m_db_prev;
  bit       m_valid, m_wait, m_ov;
  bit [3:0] m_a, m_b;

  function automatic void m_reset();
    m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
    m_db = 0; m_db_prev = 0;
    m_valid = 0; m_wait = 0; m_ov = 0;
    m_a = 0; m_b = 0;
    win = {};
    repeat (D) win.push_back(1'b0);
  endfunction

  function automatic void m_step();
    bit rise;
    bit set_ov;
    bit all_diff;
    rise   = m_db && !m_db_prev;
    set_ov = 0;
    if (m_valid) begin
      if (rise) set_ov = 1;
      if (op_ready) begin
        m_valid = 0;
        m_wait  = m_db;
      end
    end else if (m_wait) begin
      if (!m_db) m_wait = 0;
    end else if (rise) begin
      m_valid = 1;
      m_a = m_p2[7:4];
      m_b = m_p2[3:0];
    end
    m_ov = set_ov | (m_ov & !overrun_clr);
    win.push_back(m_s2);
    void'(win.pop_front());
    m_db_prev = m_db;
    all_diff = 1;
    foreach (win[i]) if (win[i] == m_db) all_diff = 0;
    if (all_diff) m_db = !m_db;
    m_s2 = m_s1; m_s1 = strobe_in;
    m_p2 = m_p1; m_p1 = pins_in;
  endfunction

  task automatic compare();
    chk("op_valid", op_valid, m_valid);
    chk("busy", busy, m_valid | m_wait);
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("overrun", overrun, m_ov);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) m_reset();
    else m_step();
    @(negedge clk);
    compare();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    m_reset();
    compare();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int first, cnt, e, cycles, len, rdy_pct;
    bit prev_v;
    logic [3:0] sa, sb;
    reset = 1'b1; pins_in = '0; strobe_in = 1'b0;
    op_ready = 1'b0; overrun_clr = 1'b0;
    m_reset();
    repeat (3) cyc();
    reset = 1'b0;

    // idle after reset
    repeat (100) cyc();
    chk("t1_busy", busy, 0);

    // basic capture latency and release
    pins_in = 8'hA5; strobe_in = 1'b1; op_ready = 1'b1;
    first = -1; cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (op_valid) begin
        cnt++;
        if (first < 0) begin
          first = i;
          chk("t2_a", op_a, 4'hA);
          chk("t2_b", op_b, 4'h5);
        end
      end
    end
    chk("t2_lat", first, 19);
    chk("t2_width", cnt, 1);
    strobe_in = 1'b0;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (!busy && first < 0) first = i;
    end
    chk("t2_rel", first, 19);

    // short pulse and bounce train never capture
    cnt = 0;
    strobe_in = 1'b1;
    repeat (10) begin cyc(); cnt += int'(op_valid); end
    strobe_in = 1'b0;
    repeat (20) begin cyc(); cnt += int'(op_valid); end
    repeat (6) begin
      strobe_in = 1'b1;
      repeat (5) begin cyc(); cnt += int'(op_valid); end
      strobe_in = 1'b0;
      repeat (5) begin cyc(); cnt += int'(op_valid); end
    end
    repeat (20) begin cyc(); cnt += int'(op_valid); end
    chk("t3_novalid", cnt, 0);

    // held operands ignore later pin changes
    pins_in = 8'h3C; strobe_in = 1'b1; op_ready = 1'b0;
    repeat (19) cyc();
    chk("t4_valid", op_valid, 1);
    pins_in = 8'hFF;
    repeat (50) cyc();
    chk("t4_a", op_a, 4'h3);
    chk("t4_b", op_b, 4'hC);
    op_ready = 1'b1;
    cyc();
    chk("t4_drop", op_valid, 0);
    op_ready = 1'b0; strobe_in = 1'b0;
    repeat (25) cyc();

    // overrun on a second press while stalled
    pins_in = 8'h6E; strobe_in = 1'b1;
    repeat (20) cyc();
    sa = op_a; sb = op_b;
    strobe_in = 1'b0; pins_in = 8'h91;
    repeat (20) cyc();
    strobe_in = 1'b1;
    repeat (20) cyc();
    chk("t5_ov", overrun, 1);
    chk("t5_a", op_a, 4'h6);
    chk("t5_b", op_b, 4'hE);
    op_ready = 1'b1;
    cyc();
    chk("t5_hs", op_valid, 0);
    op_ready = 1'b0; overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("t5_clr", overrun, 0);
    strobe_in = 1'b0;
    repeat (25) cyc();
    // clear coinciding with a dropped press: set wins
    strobe_in = 1'b1;
    repeat (20) cyc();
    strobe_in = 1'b0;
    repeat (20) cyc();
    strobe_in = 1'b1;
    repeat (18) cyc();
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("t5_setwins", overrun, 1);
    op_ready = 1'b1; cyc(); op_ready = 1'b0;
    overrun_clr = 1'b1; cyc(); overrun_clr = 1'b0;
    strobe_in = 1'b0;
    repeat (25) cyc();

    // reset mid-handshake with the strobe still held
    strobe_in = 1'b1;
    repeat (20) cyc();
    chk("t6_pre", op_valid, 1);
    reset_pulse();
    chk("t6_drop", op_valid, 0);
    first = -1; cnt = 0; prev_v = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (op_valid && !prev_v) begin
        cnt++;
        if (first < 0) first = i;
      end
      prev_v = op_valid;
    end
    chk("t6_lat", first, 19);
    chk("t6_once", cnt, 1);
    op_ready = 1'b1; strobe_in = 1'b0;
    repeat (25) cyc();

    // randomised traffic against the model
    cycles = 0;
    while (cycles < 12000) begin
      strobe_in = ~strobe_in;
      len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, D - 1)
                                         : $urandom_range(D, 3 * D);
      rdy_pct = ($urandom_range(0, 1) == 1) ? 2 : 40;
      for (e = 0; e < len; e++) begin
        pins_in     = 8'($urandom);
        op_ready    = ($urandom_range(0, 99) < rdy_pct);
        overrun_clr = ($urandom_range(0, 19) == 0);
        cyc();
        cycles++;
      end
      if ($urandom_range(0, 40) == 0) reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
